// File: rtl/coax_framed_tx_if.sv
// coax_framed_tx_if: host-side bus of the framed coax transmitter.
// Carries the enqueue port (data/last/load_strobe), the frame control inputs
// (start_strobe/abort) and the status outputs (empty, full, frames_pending,
// busy, done_strobe, aborted).
//   master : host side (drives data/control, observes status)
//   slave  : coax_framed_tx side
interface coax_framed_tx_if #(
    parameter int MAX_FRAMES = 15
);
    localparam int FW = $clog2(MAX_FRAMES + 1);

    logic [9:0]    data;
    logic          last;
    logic          load_strobe;
    logic          start_strobe;
    logic          abort;
    logic          empty;
    logic          full;
    logic [FW-1:0] frames_pending;
    logic          busy;
    logic          done_strobe;
    logic          aborted;

    modport master (
        output data, last, load_strobe, start_strobe, abort,
        input  empty, full, frames_pending, busy, done_strobe, aborted
    );

    modport slave (
        input  data, last, load_strobe, start_strobe, abort,
        output empty, full, frames_pending, busy, done_strobe, aborted
    );
endinterface

// File: rtl/coax_framed_tx.sv
// coax_framed_tx: framed, buffered transmitter for 10-bit coax words.
// A FIFO of {last, data} holds whole frames; each start request sends the
// oldest complete frame through coax_tx. An abort flushes the remainder of
// the frame in flight.
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   host        coax_framed_tx_if.slave (enqueue, start/abort, status)
//   active      coax_tx line activity
//   tx          coax serial output
//
// Build option: define COAX_FRAMED_TX_AUTO_START_EN to start a frame
// whenever one is pending, without start_strobe.
//
// Also contains the helper modules fifo_sync_ram and coax_tx.

// ---------------------------------------------------------------------------
// fifo_sync_ram: first-word-fall-through FIFO. rd_data always shows the head
// word while !empty; rd_ena pops it. Writes when full and reads when empty
// are ignored.
// ---------------------------------------------------------------------------
module fifo_sync_ram #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_ena,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ena,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ena && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ena && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ena && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// coax_tx: bi-phase line encoder. Each word goes out as 12 bit cells:
// sync bit (1), data[9:0] MSB first, even parity over data. A bit cell is
// ~bit for the first half and bit for the second half, so every cell has a
// mid-cell transition. Words handed in while a word is on the line follow
// back to back; when none is waiting, one end cell (line held high for the
// whole cell, i.e. no transition) closes the frame and active drops.
// One word of holding buffer: ready = buffer free.
// ---------------------------------------------------------------------------
module coax_tx #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data,
    input  logic       strobe,
    output logic       ready,
    output logic       active,
    output logic       tx
);
    localparam int CW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF    = CW'(CLOCKS_PER_BIT / 2);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [11:0]   shreg;
    logic          in_end;
    logic          hold_vld;
    logic [9:0]    hold_data;
    logic [11:0]   hold_word;

    assign ready     = !hold_vld;
    assign hold_word = {1'b1, hold_data, ^hold_data};
    assign tx        = active & (in_end | ((cnt < HALF) ? ~shreg[11] : shreg[11]));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            in_end    <= 1'b0;
            hold_vld  <= 1'b0;
            hold_data <= '0;
            active    <= 1'b0;
        end else begin
            if (strobe && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_data <= data;
            end
            if (!active) begin
                if (hold_vld) begin
                    active   <= 1'b1;
                    shreg    <= hold_word;
                    hold_vld <= 1'b0;
                    cnt      <= '0;
                    bit_idx  <= '0;
                    in_end   <= 1'b0;
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                if (in_end) begin
                    active <= 1'b0;
                    in_end <= 1'b0;
                end else if (bit_idx == 4'd11) begin
                    if (hold_vld) begin
                        shreg    <= hold_word;
                        bit_idx  <= '0;
                        hold_vld <= 1'b0;
                    end else begin
                        in_end <= 1'b1;
                    end
                end else begin
                    shreg   <= {shreg[10:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// coax_framed_tx top
// ---------------------------------------------------------------------------
module coax_framed_tx #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DEPTH          = 256,
    parameter int MAX_FRAMES     = 15
) (
    input  logic               clk,
    input  logic               reset,
    coax_framed_tx_if.slave    host,
    output logic               active,
    output logic               tx
);
    localparam int FW = $clog2(MAX_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, FLUSH} state_t;

    state_t        state;
    logic [FW-1:0] frames_pending;
    logic          rd_pending;   // a pop is scheduled for next clock
    logic          flush_done;   // FLUSH has discarded the frame's last word
    logic          done_strobe;
    logic          aborted;

    logic          fifo_empty, fifo_full, full_i;
    logic [10:0]   head;
    logic          head_last;
    logic          wr_ena;
    logic          tx_ready, tx_strobe, flush_discard, tx_idle;
    logic          inc, dec, start_go;

    assign head_last = head[10];
    assign full_i    = fifo_full || (frames_pending == FW'(MAX_FRAMES));
    assign wr_ena    = host.load_strobe && !full_i;

    // Abort wins over a same-cycle handoff. Consumption of the head is
    // spaced by rd_pending so the FWFT head is always settled.
    assign tx_strobe     = (state == SEND) && !host.abort && !fifo_empty &&
                           tx_ready && !rd_pending;
    assign flush_discard = (state == FLUSH) && !flush_done && !fifo_empty && !rd_pending;
    // Line quiet and nothing left in coax_tx's holding buffer.
    assign tx_idle       = !active && tx_ready;

    assign inc = wr_ena && host.last;
    assign dec = (tx_strobe || flush_discard) && head_last;

`ifdef COAX_FRAMED_TX_AUTO_START_EN
    assign start_go = (frames_pending != '0);
`else
    assign start_go = host.start_strobe && (frames_pending != '0);
`endif

    fifo_sync_ram #(.WIDTH(11), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_ena  (wr_ena),
        .wr_data ({host.last, host.data}),
        .rd_ena  (rd_pending),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    coax_tx #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_tx (
        .clk    (clk),
        .reset  (reset),
        .data   (head[9:0]),
        .strobe (tx_strobe),
        .ready  (tx_ready),
        .active (active),
        .tx     (tx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            frames_pending <= '0;
            rd_pending     <= 1'b0;
            flush_done     <= 1'b0;
            done_strobe    <= 1'b0;
            aborted        <= 1'b0;
        end else begin
            done_strobe <= 1'b0;
            rd_pending  <= tx_strobe || flush_discard;

            if (inc && !dec)
                frames_pending <= frames_pending + 1'b1;
            else if (dec && !inc)
                frames_pending <= frames_pending - 1'b1;

            case (state)
                IDLE: begin
                    if (start_go)
                        state <= SEND;
                end
                SEND: begin
                    if (host.abort) begin
                        state      <= FLUSH;
                        flush_done <= 1'b0;
                    end else if (tx_strobe && head_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tx_idle && !rd_pending) begin
                        done_strobe <= 1'b1;
                        aborted     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_discard && head_last)
                        flush_done <= 1'b1;
                    if (flush_done && tx_idle && !rd_pending) begin
                        done_strobe <= 1'b1;
                        aborted     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.empty          = fifo_empty;
    assign host.full           = full_i;
    assign host.frames_pending = frames_pending;
    assign host.busy           = (state != IDLE);
    assign host.done_strobe    = done_strobe;
    assign host.aborted        = aborted;
endmodule

// File: tb/tb_coax_framed_tx.sv
// tb_coax_framed_tx: self-checking bench for coax_framed_tx. Words expected
// on the line are queued when loaded; an independent line decoder pops and
// compares them as they come off tx.
module tb_coax_framed_tx;
    localparam int CPB   = 8;
    localparam int DEPTH = 256;
    localparam int MAXF  = 15;
    localparam int TMO   = 5000;

    logic clk = 1'b0;
    logic reset;
    logic active, tx;

    coax_framed_tx_if #(.MAX_FRAMES(MAXF)) bus ();

    coax_framed_tx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH), .MAX_FRAMES(MAXF)) dut (
        .clk    (clk),
        .reset  (reset),
        .host   (bus),
        .active (active),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int handoffs = 0;
    logic [9:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line decoder: cells aligned to the rise of active; sample mid first
    // half and mid second half of each cell.
    initial begin
        int cyc, nb, pos;
        logic h1;
        logic [11:0] sh;
        logic [9:0] w;
        cyc = 0; nb = 0; h1 = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            if (reset || !active) begin
                cyc = 0;
                nb  = 0;
            end else begin
                pos = cyc % CPB;
                if (pos == 1) h1 = tx;
                if (pos == 5 && h1 !== tx) begin
                    sh = {sh[10:0], tx};
                    nb++;
                    if (nb == 12) begin
                        nb = 0;
                        check("rx_sync", sh[11], 1'b1);
                        check("rx_parity", sh[0], ^sh[10:1]);
                        if (exp_q.size() == 0)
                            check("rx_unexpected", exp_q.size(), 1);
                        else begin
                            w = exp_q.pop_front();
                            check("rx_word", sh[10:1], w);
                        end
                    end
                end
                cyc++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.done_strobe) done_cnt++;
        if (dut.tx_strobe) handoffs++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] d, input logic l, input bit push);
        bus.data = d; bus.last = l; bus.load_strobe = 1'b1;
        step();
        bus.load_strobe = 1'b0;
        if (push) exp_q.push_back(d);
    endtask

    task automatic start();
        bus.start_strobe = 1'b1;
        step();
        bus.start_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_ab);
        int n = 0;
        while (!bus.done_strobe && n < TMO) begin step(); n++; end
        check({tag, "_done"}, bus.done_strobe, 1'b1);
        check({tag, "_aborted"}, bus.aborted, exp_ab);
        step();
        check({tag, "_busy_after"}, bus.busy, 1'b0);
    endtask

    initial begin
        int n, d0;
        reset = 1'b1;
        bus.data = '0; bus.last = 1'b0; bus.load_strobe = 1'b0;
        bus.start_strobe = 1'b0; bus.abort = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // reset state
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_fp", bus.frames_pending, 0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done_strobe, 1'b0);
        check("rst_aborted", bus.aborted, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_tx", tx, 1'b0);

`ifdef COAX_FRAMED_TX_AUTO_START_EN
        // auto start: no start_strobe needed
        load(10'h155, 1'b1, 1);
        step(); step();
        check("auto_busy", bus.busy, 1'b1);
        wait_done("auto", 1'b0);
        check("auto_fp", bus.frames_pending, 0);
`else
        // 3-word frame
        load(10'h123, 1'b0, 1);
        load(10'h2AA, 1'b0, 1);
        load(10'h355, 1'b1, 1);
        check("t1_fp1", bus.frames_pending, 1);
        check("t1_empty", bus.empty, 1'b0);
        d0 = done_cnt;
        start();
        check("t1_busy", bus.busy, 1'b1);
        n = 0;
        while (bus.frames_pending != 0 && n < TMO) begin step(); n++; end
        check("t1_fp0", bus.frames_pending, 0);
        wait_done("t1", 1'b0);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_q", exp_q.size(), 0);
        check("t1_empty_end", bus.empty, 1'b1);

        // two frames, one start each
        load(10'h011, 1'b0, 1);
        load(10'h022, 1'b1, 1);
        load(10'h033, 1'b1, 1);
        check("t2_fp2", bus.frames_pending, 2);
        start();
        wait_done("t2a", 1'b0);
        check("t2a_fp", bus.frames_pending, 1);
        check("t2a_q", exp_q.size(), 1);
        repeat (20) step();
        check("t2_idle_between", bus.busy, 1'b0);
        start();
        wait_done("t2b", 1'b0);
        check("t2b_fp", bus.frames_pending, 0);
        check("t2b_q", exp_q.size(), 0);

        // start with only an unterminated word queued
        load(10'h0F0, 1'b0, 0);
        start();
        check("t3_busy", bus.busy, 1'b0);
        repeat (20) step();
        check("t3_active", active, 1'b0);
        check("t3_busy_late", bus.busy, 1'b0);
        do_reset();
        check("t3_rst_empty", bus.empty, 1'b1);

        // abort after 2nd handoff
        for (int i = 0; i < 5; i++)
            load(10'h101 + 10'(i), (i == 4), (i < 2));
        load(10'h1FF, 1'b1, 1);
        check("t4_fp2", bus.frames_pending, 2);
        handoffs = 0;
        start();
        n = 0;
        while (handoffs < 2 && n < TMO) begin step(); n++; end
        check("t4_handoffs", handoffs, 2);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        wait_done("t4abort", 1'b1);
        check("t4_fp_after", bus.frames_pending, 1);
        start();
        wait_done("t4next", 1'b0);
        check("t4_fp0", bus.frames_pending, 0);
        check("t4_q", exp_q.size(), 0);
        check("t4_empty", bus.empty, 1'b1);

        // FIFO depth limit
        for (int i = 0; i < DEPTH; i++)
            load(10'(i), 1'b0, 0);
        check("t5_full", bus.full, 1'b1);
        load(10'h3FF, 1'b1, 0);
        check("t5_drop_fp", bus.frames_pending, 0);
        check("t5_full2", bus.full, 1'b1);
        do_reset();

        // frame count limit
        for (int i = 0; i < MAXF; i++)
            load(10'h200 + 10'(i), 1'b1, 0);
        check("t5_fpmax", bus.frames_pending, MAXF);
        check("t5_fullf", bus.full, 1'b1);
        load(10'h3EE, 1'b1, 0);
        check("t5_fpmax2", bus.frames_pending, MAXF);
        do_reset();

        // reset during SEND
        load(10'h2C3, 1'b1, 0);
        start();
        n = 0;
        while (!active && n < TMO) begin step(); n++; end
        check("t6_active", active, 1'b1);
        repeat (3) step();
        d0 = done_cnt;
        do_reset();
        check("t6_empty", bus.empty, 1'b1);
        check("t6_fp", bus.frames_pending, 0);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_done", bus.done_strobe, 1'b0);
        check("t6_active_off", active, 1'b0);
        repeat (5) step();
        check("t6_done_cnt", done_cnt - d0, 0);
`endif
        check("end_q", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
